// File: rtl/alu_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_if
// Bundles every signal between the main control unit and the ALU op sequencer.
//   Handshake : op_valid / op_ready / alu_op, plus flush (abort).
//   Flags     : flag_eq / flag_gt / flag_lt from the ALU comparator.
//   Controls  : alu_ctrl, shifter_ctrl, m_shifter, m_aluout, ulaaux_ctrl,
//               uc_ctrl, uc_op, branch_taken, aluout_we, done, op_err.
// Modports:
//   master - control-unit side (drives handshake and flags, reads controls)
//   slave  - sequencer side
// -----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
  parameter int OP_W = 4
) ();

  logic            flush;
  logic            op_valid;
  logic            op_ready;
  logic [OP_W-1:0] alu_op;
  logic            flag_eq;
  logic            flag_gt;
  logic            flag_lt;
  logic [2:0]      alu_ctrl;
  logic [2:0]      shifter_ctrl;
  logic            m_shifter;
  logic [2:0]      m_aluout;
  logic [1:0]      ulaaux_ctrl;
  logic            uc_ctrl;
  logic [1:0]      uc_op;
  logic            branch_taken;
  logic            aluout_we;
  logic            done;
  logic            op_err;

  modport master (
    output flush, op_valid, alu_op, flag_eq, flag_gt, flag_lt,
    input  op_ready, alu_ctrl, shifter_ctrl, m_shifter, m_aluout, ulaaux_ctrl,
           uc_ctrl, uc_op, branch_taken, aluout_we, done, op_err
  );

  modport slave (
    input  flush, op_valid, alu_op, flag_eq, flag_gt, flag_lt,
    output op_ready, alu_ctrl, shifter_ctrl, m_shifter, m_aluout, ulaaux_ctrl,
           uc_ctrl, uc_op, branch_taken, aluout_we, done, op_err
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Accepts one ALU opcode per valid/ready handshake and sequences the ALU,
// shifter, auxiliary ALU and ALUOut mux of the multicycle datapath.
// Single-cycle ops and illegal codes run one EXEC cycle; SHIFT_L1, SHIFT_R,
// SHIFT_RA1 and LUI run LOAD -> SHIFT -> WAIT x SHIFT_WAIT -> FIN.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - alu_op_sequencer_if.slave (handshake, flags, control outputs)
// Parameters:
//   OP_W       - opcode width (>= 4); any set bit above [3:0] is illegal
//   SHIFT_WAIT - settle cycles after the shift operate cycle (0..15)
//   CNT_W      - wait counter width, must hold SHIFT_WAIT
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int OP_W       = 4,
  parameter int SHIFT_WAIT = 1,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_op_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_LOAD,
    S_SHIFT,
    S_WAIT,
    S_FIN
  } state_e;

  // Every registered control output; branch_taken is derived from these.
  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic [2:0] shifter_ctrl;
    logic       m_shifter;
    logic [2:0] m_aluout;
    logic [1:0] ulaaux_ctrl;
    logic       uc_ctrl;
    logic [1:0] uc_op;
    logic       aluout_we;
    logic       done;
    logic       op_err;
  } ctrl_t;

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'((SHIFT_WAIT > 0) ? SHIFT_WAIT - 1 : 0);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             cond;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op >> 4) == '0;
  endfunction

  function automatic logic op_is_shift(input logic [OP_W-1:0] op);
    return op_legal(op) && (op[3:0] inside {4'd5, 4'd7, 4'd8, 4'd15});
  endfunction

  // Control word for the state being entered, given the latched opcode.
  // Computing it from the next state is what makes the outputs registered
  // yet aligned with the state they belong to.
  function automatic ctrl_t ctrl_for(input state_e st, input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      S_EXEC: begin
        c.done = 1'b1;
        if (!op_legal(op)) begin
          c.op_err = 1'b1;
        end else begin
          case (op[3:0])
            4'd0, 4'd1, 4'd2, 4'd3: begin
              c.alu_ctrl  = op[2:0];
              c.m_aluout  = 3'b001;
              c.aluout_we = 1'b1;
            end
            4'd4: c.aluout_we = 1'b1;
            4'd6: begin
              c.ulaaux_ctrl = 2'b10;
              c.aluout_we   = 1'b1;
            end
            4'd9: begin
              c.ulaaux_ctrl = 2'b01;
              c.aluout_we   = 1'b1;
            end
            4'd10: begin
              c.alu_ctrl  = 3'b111;
              c.m_aluout  = 3'b011;
              c.aluout_we = 1'b1;
            end
            4'd11, 4'd12, 4'd13, 4'd14: begin
              c.alu_ctrl = 3'b111;
              c.m_aluout = 3'b011;
              c.uc_ctrl  = 1'b1;
              c.uc_op    = 2'(op[3:0] - 4'd11);
            end
            default: ;
          endcase
        end
      end
      S_LOAD, S_SHIFT, S_WAIT, S_FIN: begin
        c.m_aluout  = 3'b010;
        c.m_shifter = (op[3:0] == 4'd15);
        if (st == S_LOAD) begin
          c.shifter_ctrl = 3'b001;
        end else if (st == S_SHIFT) begin
          case (op[3:0])
            4'd7:    c.shifter_ctrl = 3'b011;
            4'd8:    c.shifter_ctrl = 3'b100;
            default: c.shifter_ctrl = 3'b010;
          endcase
        end else if (st == S_FIN) begin
          c.aluout_we = 1'b1;
          c.done      = 1'b1;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (bus.flush) begin
      // Abort from any state; in IDLE this also blocks acceptance.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.op_valid) begin
            op_d    = bus.alu_op;
            state_d = op_is_shift(bus.alu_op) ? S_LOAD : S_EXEC;
          end
        end
        S_EXEC:  state_d = S_IDLE;
        S_LOAD:  state_d = S_SHIFT;
        S_SHIFT: begin
          if (SHIFT_WAIT == 0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_d = S_FIN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    ctrl_d = ctrl_for(state_d, op_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Branch condition follows the live flags during the EXEC cycle.
  always_comb begin
    case (ctrl_q.uc_op)
      2'b00:   cond = bus.flag_eq;
      2'b01:   cond = !bus.flag_eq;
      2'b10:   cond = bus.flag_lt | bus.flag_eq;
      default: cond = bus.flag_gt;
    endcase
  end

  assign bus.branch_taken = (state_q == S_EXEC) && ctrl_q.uc_ctrl && cond;
  assign bus.op_ready     = (state_q == S_IDLE);
  assign bus.alu_ctrl     = ctrl_q.alu_ctrl;
  assign bus.shifter_ctrl = ctrl_q.shifter_ctrl;
  assign bus.m_shifter    = ctrl_q.m_shifter;
  assign bus.m_aluout     = ctrl_q.m_aluout;
  assign bus.ulaaux_ctrl  = ctrl_q.ulaaux_ctrl;
  assign bus.uc_ctrl      = ctrl_q.uc_ctrl;
  assign bus.uc_op        = ctrl_q.uc_op;
  assign bus.aluout_we    = ctrl_q.aluout_we;
  assign bus.done         = ctrl_q.done;
  assign bus.op_err       = ctrl_q.op_err;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Parametrised successor to the multicycle ALU control decoder.
- Accepts one ALU opcode per valid/ready handshake and replaces the external COUNTER with an internal FSM.
- Sequences the shifter through load, operate and a configurable settle phase, resolves branch conditions from ALU flags, and signals completion with a done pulse.
- Sits between the main control unit and the ALU / shifter / ulaaux / ALUOut mux of the multicycle datapath.

Parameters:
- OP_W, 4: opcode width, must be >= 4. Codes with any bit above [3:0] set are illegal.
- SHIFT_WAIT, 1: cycles shifter_ctrl is held at 000 after the operate cycle, before the result is captured. Range 0..15.
- CNT_W, 4: width of the internal wait counter. Must hold SHIFT_WAIT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the current operation.
- op_valid  in  1  opcode offered.
- op_ready  out  1  block can accept an opcode.
- alu_op  in  OP_W  opcode: 0 NO_OP, 1 ADD, 2 SUB, 3 AND, 4 PASS_B, 5 SHIFT_L1, 6 SHIFT_L2, 7 SHIFT_R, 8 SHIFT_RA1, 9 SHIFT_RA2, 10 SLTI, 11 BEQ, 12 BNE, 13 BLE, 14 BGT, 15 LUI.
- flag_eq, flag_gt, flag_lt  in  1 each  ALU compare flags, sampled in EXEC.
- alu_ctrl  out  3  ALU function.
- shifter_ctrl  out  3  shifter command.
- m_shifter  out  1  shifter input mux select.
- m_aluout  out  3  ALUOut source mux select.
- ulaaux_ctrl  out  2  auxiliary ALU command.
- uc_ctrl  out  1  branch-compare active.
- uc_op  out  2  branch type.
- branch_taken  out  1  branch condition result.
- aluout_we  out  1  ALUOut register write enable.
- done  out  1  one-cycle completion pulse.
- op_err  out  1  illegal opcode flag, same cycle as done.

Behaviour:
- Reset (reset=0) forces state IDLE immediately, in any state. All registered outputs go to 0 and no done is produced for an interrupted operation.
- op_ready = (state==IDLE), combinational, so it reads 1 while reset is asserted.
- States: IDLE, EXEC, LOAD, SHIFT, WAIT, FIN.
- Acceptance: op_valid & op_ready at a clock edge latches alu_op. Single-cycle ops and illegal codes go to EXEC; 5, 7, 8 and 15 go to LOAD.
- In IDLE, every control output is 0. The block does not hold the previous op's controls.
- Controls are registered: they reflect the op from the first cycle after acceptance.
- EXEC lasts 1 cycle, then IDLE. done=1 in EXEC. Controls per op:
  - NO_OP: alu 000, m_aluout 001.
  - ADD: alu 001, m_aluout 001.
  - SUB: alu 010, m_aluout 001.
  - AND: alu 011, m_aluout 001.
  - PASS_B: m_aluout 000.
  - SHIFT_L2: ulaaux 10, m_aluout 000.
  - SHIFT_RA2: ulaaux 01, m_aluout 000.
  - SLTI: alu 111, m_aluout 011.
  - For all of the above, aluout_we=1.
- Branches (BEQ, BNE, BLE, BGT) in EXEC:
  - alu 111, m_aluout 011, uc_ctrl 1, uc_op 00/01/10/11 respectively, aluout_we 0.
  - branch_taken from flags sampled in EXEC: BEQ eq; BNE !eq; BLE lt|eq; BGT gt.
  - branch_taken is 0 at all other times.
- Shift sequence for SHIFT_L1, SHIFT_R, SHIFT_RA1, LUI:
  - LOAD: shifter 001.
  - SHIFT: shifter 010 for SHIFT_L1 and LUI, 011 for SHIFT_R, 100 for SHIFT_RA1.
  - WAIT: SHIFT_WAIT cycles, shifter 000. The counter loads SHIFT_WAIT-1 on entry and exits at 0. WAIT is skipped when SHIFT_WAIT=0.
  - FIN: shifter 000, aluout_we 1, done 1, then IDLE.
  - m_aluout=010 and m_shifter (1 only for LUI) are held from LOAD through FIN.
  - done occurs 3+SHIFT_WAIT cycles after acceptance.
- Illegal opcode: goes to EXEC with all controls 0, aluout_we 0, done 1, op_err 1.
- flush=1 in any non-IDLE state: next edge goes to IDLE with controls 0 and no done or aluout_we.
- flush=1 in IDLE blocks acceptance on that edge; flush has priority over op_valid.
- op_valid while not ready is ignored and alu_op is not sampled. The sender must hold op_valid/alu_op until accepted.
- Back-to-back operation: op_ready=1 in the cycle after done, giving a sustained throughput of 1 op per 2 cycles for single-cycle ops.

Test Plan:
- Reset release, then ADD (alu_op=1) with op_valid=1 -> op_ready=1 while in reset; one cycle after accept alu_ctrl=001, m_aluout=001, aluout_we=1, done=1; next cycle all controls 0, op_ready=1.
- SHIFT_R with SHIFT_WAIT=2 -> shifter_ctrl sequence 001, 011, 000, 000, 000 over 5 cycles; done and aluout_we only in the 5th; m_aluout=010 throughout; m_shifter=0.
- LUI with SHIFT_WAIT=0 -> shifter_ctrl 001, 010, 000; m_shifter=1 for all 3 cycles; done in the 3rd cycle.
- BLE with flag_lt=0, flag_eq=1 -> branch_taken=1, uc_ctrl=1, uc_op=10, aluout_we=0; BGT with flag_gt=0 -> branch_taken=0.
- SHIFT_RA1 accepted, flush=1 during the SHIFT cycle -> IDLE next edge, no done; reset=0 asserted mid-WAIT in a separate run -> outputs 0 immediately, no done.
- OP_W=5 build, alu_op=5'b10001 -> done=1, op_err=1, all controls 0; op_valid held while busy -> second op accepted only once op_ready returns to 1.
